// File: rtl/ex_mem_skid.sv
// ex_mem_skid: pipeline boundary between the EX and MEM stages.
//
// Captures an EX result only when the ALU reports completion and holds up to
// two results (head + skid) so MEM back-pressure never drops or duplicates a
// result. The head entry drives the mem_* outputs under a valid/ready
// handshake. A saturating counter records EX multi-cycle stall cycles.
//
// State table:
//   state | meaning
//   EMPTY | no valid entry; mem_valid_o=0, ex_ready_o=1
//   ONE   | head valid, skid empty; mem_valid_o=1, ex_ready_o=1
//   FULL  | head and skid valid; mem_valid_o=1, ex_ready_o=0
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-low reset
//   flush_i              empties the buffer (discards a same-cycle accept)
//   ex_*_i / ex_ready_o  EX-side result and back-pressure
//   mem_*_o / mem_ready_i head entry towards MEM and its consume strobe
//   stall_cnt_o          cycles with ex_valid_i=1 and ex_ok_i=0, saturating

module ex_mem_skid #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    ex_valid_i,
    input  logic                    ex_ok_i,
    input  logic [REG_ADDR_W-1:0]   ex_wd_i,
    input  logic                    ex_wreg_i,
    input  logic                    ex_whilo_i,
    input  logic [2*DATA_W-1:0]     ex_wdata_i,
    output logic                    ex_ready_o,
    output logic                    mem_valid_o,
    input  logic                    mem_ready_i,
    output logic [REG_ADDR_W-1:0]   mem_wd_o,
    output logic                    mem_wreg_o,
    output logic                    mem_whilo_o,
    output logic [DATA_W-1:0]       mem_wdata_o,
    output logic [DATA_W-1:0]       mem_hi_o,
    output logic [DATA_W-1:0]       mem_lo_o,
    output logic [CNT_W-1:0]        stall_cnt_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  wreg;
        logic                  whilo;
        logic [2*DATA_W-1:0]   wdata;
    } entry_t;

    state_t             state_q, state_d;
    entry_t             head_q, head_d;
    entry_t             skid_q, skid_d;
    logic               ready_q, ready_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    entry_t             in_entry;
    logic               accept;
    logic               pop;

    assign in_entry = '{wd: ex_wd_i, wreg: ex_wreg_i, whilo: ex_whilo_i, wdata: ex_wdata_i};

    assign mem_valid_o = (state_q != EMPTY);
    assign accept      = ex_valid_i & ex_ok_i & ready_q;
    assign pop         = mem_valid_o & mem_ready_i;

    // State register (and all other storage).
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            ready_q     <= 1'b1;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            ready_q     <= ready_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !pop)      state_d = FULL;
                    else if (!accept && pop) state_d = EMPTY;
                end
                FULL:  if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Output / datapath logic. Payloads are left stale on flush; the
    // enables seen by MEM are masked by mem_valid_o instead.
    always_comb begin
        head_d      = head_q;
        skid_d      = skid_q;
        stall_cnt_d = stall_cnt_q;
        if (!flush_i) begin
            unique case (state_q)
                EMPTY: if (accept) head_d = in_entry;
                ONE: begin
                    if (accept && pop) head_d = in_entry;
                    else if (accept)   skid_d = in_entry;
                end
                FULL:  if (pop) head_d = skid_q;
                default: ;
            endcase
        end
        // ex_ready_o is registered so MEM's ready never reaches EX combinationally.
        ready_d = (state_d != FULL);
        if (ex_valid_i && !ex_ok_i && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    assign ex_ready_o  = ready_q;
    assign mem_wd_o    = head_q.wd;
    assign mem_wreg_o  = head_q.wreg & mem_valid_o;
    assign mem_whilo_o = head_q.whilo & mem_valid_o;
    assign mem_wdata_o = head_q.wdata[DATA_W-1:0];
    assign mem_lo_o    = head_q.wdata[DATA_W-1:0];
    assign mem_hi_o    = head_q.wdata[2*DATA_W-1:DATA_W];
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: directed scenarios plus random traffic. The
// reference model is a plain FIFO queue of capacity two plus a saturating
// integer stall count; a negedge monitor compares the DUT head against it.

module tb_ex_mem_skid;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic        ex_ok_i = 1'b0;
    logic [4:0]  ex_wd_i = '0;
    logic        ex_wreg_i = 1'b0;
    logic        ex_whilo_i = 1'b0;
    logic [63:0] ex_wdata_i = '0;
    logic        mem_ready_i = 1'b0;

    logic        ex_ready_o, mem_valid_o, mem_wreg_o, mem_whilo_o;
    logic [4:0]  mem_wd_o;
    logic [31:0] mem_wdata_o, mem_hi_o, mem_lo_o, stall_cnt_o;

    logic        s_ex_ready, s_mem_valid, s_mem_wreg, s_mem_whilo;
    logic [4:0]  s_mem_wd;
    logic [31:0] s_mem_wdata, s_mem_hi, s_mem_lo;
    logic [3:0]  s_stall_cnt;

    always #5 clk_i = ~clk_i;

    ex_mem_skid u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_ok_i(ex_ok_i), .ex_wd_i(ex_wd_i),
        .ex_wreg_i(ex_wreg_i), .ex_whilo_i(ex_whilo_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(ex_ready_o), .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_wd_o(mem_wd_o), .mem_wreg_o(mem_wreg_o), .mem_whilo_o(mem_whilo_o),
        .mem_wdata_o(mem_wdata_o), .mem_hi_o(mem_hi_o), .mem_lo_o(mem_lo_o),
        .stall_cnt_o(stall_cnt_o)
    );

    ex_mem_skid #(.CNT_W(4)) u_sat (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .ex_valid_i(ex_valid_i), .ex_ok_i(ex_ok_i), .ex_wd_i(ex_wd_i),
        .ex_wreg_i(ex_wreg_i), .ex_whilo_i(ex_whilo_i), .ex_wdata_i(ex_wdata_i),
        .ex_ready_o(s_ex_ready), .mem_valid_o(s_mem_valid), .mem_ready_i(mem_ready_i),
        .mem_wd_o(s_mem_wd), .mem_wreg_o(s_mem_wreg), .mem_whilo_o(s_mem_whilo),
        .mem_wdata_o(s_mem_wdata), .mem_hi_o(s_mem_hi), .mem_lo_o(s_mem_lo),
        .stall_cnt_o(s_stall_cnt)
    );

    typedef struct {
        logic [4:0]  wd;
        logic        wreg;
        logic        whilo;
        logic [63:0] wdata;
    } item_t;

    item_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    longint      stall_model = 0;
    int          sat_model = 0;
    bit          mon_en = 0;

    // Effects of the inputs currently driven, applied at the next rising edge.
    bit          pend_rst = 1;
    bit          pend_flush = 0;
    bit          pend_acc = 0;
    bit          pend_stall = 0;
    item_t       pend_item;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock of stimulus: commit the previous cycle into the model, then drive.
    task automatic step(input bit v, input bit ok, input logic [4:0] wd, input bit wreg,
                        input bit whilo, input logic [63:0] wdata, input bit mrdy,
                        input bit fl, input bit rst);
        @(posedge clk_i);
        if (pend_rst) begin
            exp_q.delete();
            stall_model = 0;
            sat_model = 0;
        end else begin
            if (pend_stall) begin
                if (stall_model < 64'hFFFF_FFFF) stall_model++;
                if (sat_model < 15) sat_model++;
            end
            if (pend_flush) exp_q.delete();
            else if (pend_acc) exp_q.push_back(pend_item);
        end
        mon_en = 1;
        #1;
        ex_valid_i  = v;
        ex_ok_i     = ok;
        ex_wd_i     = wd;
        ex_wreg_i   = wreg;
        ex_whilo_i  = whilo;
        ex_wdata_i  = wdata;
        mem_ready_i = mrdy;
        flush_i     = fl;
        rst_i       = !rst;
        pend_rst    = rst;
        pend_flush  = fl;
        pend_stall  = v && !ok;
        pend_acc    = v && ok && (exp_q.size() < 2);
        pend_item   = '{wd: wd, wreg: wreg, whilo: whilo, wdata: wdata};
    endtask

    task automatic idle(input bit mrdy, input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, '0, mrdy, 0, 0);
    endtask

    task automatic push(input logic [4:0] wd, input bit wreg, input bit whilo,
                        input logic [63:0] wdata, input bit mrdy);
        step(1, 1, wd, wreg, whilo, wdata, mrdy, 0, 0);
    endtask

    // Monitor: compares the DUT against the model; consumes the head on pop.
    always @(negedge clk_i) begin
        if (mon_en) begin
            chk("ex_ready", ex_ready_o, exp_q.size() < 2);
            chk("mem_valid", mem_valid_o, exp_q.size() > 0);
            chk("stall_cnt", stall_cnt_o, stall_model[31:0]);
            chk("sat_cnt", s_stall_cnt, sat_model[3:0]);
            if (exp_q.size() > 0) begin
                chk("mem_wd", mem_wd_o, exp_q[0].wd);
                chk("mem_wreg", mem_wreg_o, exp_q[0].wreg);
                chk("mem_whilo", mem_whilo_o, exp_q[0].whilo);
                chk("mem_wdata", mem_wdata_o, exp_q[0].wdata[31:0]);
                chk("mem_lo", mem_lo_o, exp_q[0].wdata[31:0]);
                chk("mem_hi", mem_hi_o, exp_q[0].wdata[63:32]);
                if (mem_ready_i) void'(exp_q.pop_front());
            end else begin
                chk("idle_wreg", mem_wreg_o, 1'b0);
                chk("idle_whilo", mem_whilo_o, 1'b0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle.
        step(0, 0, '0, 0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 0, 0, '0, 0, 0, 1);
        idle(0, 3);

        // Streaming with MEM always ready, back-to-back entries.
        push(5'd5, 1, 0, 64'h0000_0000_DEAD_BEEF, 1);
        push(5'd6, 1, 0, 64'h0000_0000_1234_5678, 1);
        idle(1, 3);

        // Back-pressure: A, B fill the buffer, C is refused.
        push(5'd1, 1, 0, 64'h11, 0);
        push(5'd2, 1, 0, 64'h22, 0);
        push(5'd3, 1, 0, 64'h33, 0);
        idle(0, 2);
        idle(1, 4);

        // Multi-cycle EX: 33 stall cycles then one HI/LO result.
        step(0, 0, '0, 0, 0, '0, 0, 0, 1);
        for (int i = 0; i < 33; i++) step(1, 0, 5'd9, 0, 1, 64'h0000_0002_0000_0003, 0, 0, 0);
        push(5'd9, 0, 1, 64'h0000_0002_0000_0003, 0);
        idle(0, 1);
        @(negedge clk_i);
        chk("stall_33", stall_cnt_o, 32'd33);
        chk("hilo_hi", mem_hi_o, 32'd2);
        chk("hilo_lo", mem_lo_o, 32'd3);
        idle(1, 3);

        // Flush in FULL with a simultaneous pop.
        push(5'd10, 1, 0, 64'hA, 0);
        push(5'd11, 1, 0, 64'hB, 0);
        idle(0, 1);
        step(0, 0, '0, 0, 0, '0, 1, 1, 0);
        idle(1, 2);

        // Flush with a simultaneous accept while EMPTY.
        step(1, 1, 5'd12, 1, 1, 64'hC, 1, 1, 0);
        idle(1, 2);

        // Reset mid-operation in FULL with stall count 7.
        step(0, 0, '0, 0, 0, '0, 0, 0, 1);
        push(5'd13, 1, 0, 64'hD, 0);
        push(5'd14, 1, 0, 64'hE, 0);
        for (int i = 0; i < 7; i++) step(1, 0, '0, 0, 0, '0, 0, 0, 0);
        idle(0, 1);
        @(negedge clk_i);
        chk("pre_rst_cnt", stall_cnt_o, 32'd7);
        step(0, 0, '0, 0, 0, '0, 0, 0, 1);
        idle(1, 1);
        @(negedge clk_i);
        chk("post_rst_cnt", stall_cnt_o, 32'd0);
        chk("post_rst_valid", mem_valid_o, 1'b0);

        // Saturation of the 4-bit counter instance.
        for (int i = 0; i < 20; i++) step(1, 0, '0, 0, 0, '0, 1, 0, 0);
        idle(1, 1);
        @(negedge clk_i);
        chk("sat_15", s_stall_cnt, 4'd15);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom),
                 1'($urandom), 1'($urandom), {$urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 199) == 0);
        end
        idle(1, 4);

        @(negedge clk_i);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
